line_serializer: RTL and testbench

//  Downstream consumer of the 8*WIDTH-bit line FIFO in the IO path.

---
 rtl/line_serializer_if.sv | 26 ++
 rtl/line_serializer.sv | 111 +++++++++++
 tb/tb_line_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/line_serializer_if.sv
// rtl/line_serializer_if.sv - FIFO-side and byte-stream-side signals of the line serializer.
// master: serializer view; slave: FIFO/sink (testbench) view.
interface line_serializer_if #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 16
);
  logic [8*WIDTH-1:0] fifo_data;
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic [CNT_W-1:0]   lines_sent;

  modport master (
    input  fifo_data, fifo_empty, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last, busy, lines_sent
  );

  modport slave (
    output fifo_data, fifo_empty, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last, busy, lines_sent
  );
endinterface

// File: rtl/line_serializer.sv
// rtl/line_serializer.sv - pops FWFT FIFO lines and streams them out byte 0 first.
// Optional LINE_SERIALIZER_CHECKSUM_EN appends a (-sum mod 256) byte to every line.
module line_serializer #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               rst_n,
  line_serializer_if.master  bus
);
  localparam int IDX_W = $clog2(WIDTH);

`ifdef LINE_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [8*WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic               r_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_hs;
  logic               w_at_end;
  logic               w_line_done;
  logic               w_pop;

  assign w_hs     = r_valid & bus.out_ready;
  assign w_at_end = (r_idx == IDX_W'(WIDTH - 1));

`ifdef LINE_SERIALIZER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_data_end;
  assign w_data_end  = (r_state == SEND) & w_hs & w_at_end;
  assign w_line_done = (r_state == CSUM) & w_hs;
`else
  assign w_line_done = (r_state == SEND) & w_hs & w_at_end;
`endif

  // Pop either from idle or on the closing handshake, which gives zero-bubble lines.
  assign w_pop = rst_n & ~bus.fifo_empty & ((r_state == IDLE) | w_line_done);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_pop) w_next = SEND;
`ifdef LINE_SERIALIZER_CHECKSUM_EN
      SEND: if (w_data_end) w_next = CSUM;
      CSUM: if (w_line_done) w_next = w_pop ? SEND : IDLE;
`else
      SEND: if (w_line_done && !w_pop) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
`ifdef LINE_SERIALIZER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      if (w_pop) begin
        r_shift <= bus.fifo_data;
        r_idx   <= '0;
        r_valid <= 1'b1;
`ifdef LINE_SERIALIZER_CHECKSUM_EN
        r_sum   <= '0;
`endif
      end else if (w_hs) begin
        if (r_state == SEND) begin
          r_shift <= r_shift >> 8;
          if (!w_at_end) r_idx <= r_idx + IDX_W'(1);
`ifdef LINE_SERIALIZER_CHECKSUM_EN
          // On the last data byte r_sum turns into the checksum byte itself.
          if (w_at_end) r_sum <= 8'd0 - (r_sum + r_shift[7:0]);
          else          r_sum <= r_sum + r_shift[7:0];
`endif
        end
        if (w_line_done) r_valid <= 1'b0;
      end
      if (w_line_done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef LINE_SERIALIZER_CHECKSUM_EN
  assign bus.out_data = (r_state == CSUM) ? r_sum : r_shift[7:0];
  assign bus.out_last = (r_state == CSUM);
`else
  assign bus.out_data = r_shift[7:0];
  assign bus.out_last = (r_state == SEND) & w_at_end;
`endif
  assign bus.out_valid  = r_valid;
  assign bus.fifo_rd_en = w_pop;
  assign bus.busy       = (r_state != IDLE);
  assign bus.lines_sent = r_cnt;
endmodule

// File: tb/tb_line_serializer.sv
// tb/tb_line_serializer.sv - directed bench for line_serializer at WIDTH=4.
module tb_line_serializer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 16;
`ifdef LINE_SERIALIZER_CHECKSUM_EN
  localparam int BPL = WIDTH + 1;
`else
  localparam int BPL = WIDTH;
`endif

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  line_serializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();
  line_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int stall_viol = 0;
  int empty_viol = 0;
  logic [31:0] q[$];
  logic [7:0]  cap_d[$];
  logic        cap_l[$];
  int          cap_c[$];
  int          pop_at[$];
  logic        prev_stall;
  logic [7:0]  prev_d;
  logic        prev_l;

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
    logic [7:0] s;
    s = 8'd0;
    if (k < WIDTH) return w[8*k +: 8];
    for (int i = 0; i < WIDTH; i++) s = s + w[8*i +: 8];
    return 8'd0 - s;
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty = (q.size() == 0);
    bus.fifo_data  = (q.size() == 0) ? '0 : q[0];
  endtask

  task automatic clear_cap();
    cap_d.delete(); cap_l.delete(); cap_c.delete(); pop_at.delete();
    stall_viol = 0; empty_viol = 0; prev_stall = 1'b0;
  endtask

  // Inputs change at posedge+1, outputs are sampled at negedge.
  task automatic cycle(input logic rdy);
    logic pop;
    bus.out_ready = rdy;
    @(negedge CLK);
    pop = bus.fifo_rd_en;
    if (pop && bus.fifo_empty) empty_viol++;
    if (prev_stall && (!bus.out_valid || bus.out_data !== prev_d || bus.out_last !== prev_l))
      stall_viol++;
    if (bus.out_valid && bus.out_ready) begin
      cap_d.push_back(bus.out_data);
      cap_l.push_back(bus.out_last);
      cap_c.push_back(cyc);
    end
    if (pop) pop_at.push_back(cap_d.size());
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_d = bus.out_data;
    prev_l = bus.out_last;
    @(posedge CLK); #1;
    if (pop && q.size() > 0) void'(q.pop_front());
    cyc++;
    drive_fifo();
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    q.push_back(32'h44332211);
    drive_fifo();
    #12;
    n_vec++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b want 0", bus.fifo_rd_en); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.lines_sent !== 16'd0) begin n_err++; $display("FAIL reset_lines got %0d want 0", bus.lines_sent); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.out_data); end
    q.delete();
    drive_fifo();
    @(posedge CLK); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int start;
    clear_cap();
    start = cyc;
    q.push_back(32'h44332211);
    drive_fifo();
    repeat (12) cycle(1'b1);
    n_vec++; if (cap_d.size() !== BPL) begin n_err++; $display("FAIL single_count got %0d want %0d", cap_d.size(), BPL); end
    for (int k = 0; k < BPL && k < cap_d.size(); k++) begin
      n_vec++; if (cap_d[k] !== exp_byte(32'h44332211, k)) begin n_err++; $display("FAIL single_byte%0d got %h want %h", k, cap_d[k], exp_byte(32'h44332211, k)); end
      n_vec++; if (cap_l[k] !== (k == BPL-1)) begin n_err++; $display("FAIL single_last%0d got %b want %b", k, cap_l[k], (k == BPL-1)); end
    end
    if (cap_c.size() > 0) begin
      n_vec++; if (cap_c[0] - start !== 1) begin n_err++; $display("FAIL single_latency got %0d want 1", cap_c[0] - start); end
    end
    n_vec++; if (pop_at.size() !== 1) begin n_err++; $display("FAIL single_pops got %0d want 1", pop_at.size()); end
    n_vec++; if (bus.lines_sent !== 16'd1) begin n_err++; $display("FAIL single_lines got %0d want 1", bus.lines_sent); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle got %b want 0", bus.busy); end
    n_vec++; if (empty_viol !== 0) begin n_err++; $display("FAIL single_rd_empty got %0d want 0", empty_viol); end
  endtask

  task automatic test_backpressure();
    clear_cap();
    q.push_back(32'hDDCCBBAA);
    drive_fifo();
    for (int i = 0; i < 24; i++) cycle((i % 4 == 0) || (i % 4 == 3));
    n_vec++; if (cap_d.size() !== BPL) begin n_err++; $display("FAIL bp_count got %0d want %0d", cap_d.size(), BPL); end
    for (int k = 0; k < BPL && k < cap_d.size(); k++) begin
      n_vec++; if (cap_d[k] !== exp_byte(32'hDDCCBBAA, k)) begin n_err++; $display("FAIL bp_byte%0d got %h want %h", k, cap_d[k], exp_byte(32'hDDCCBBAA, k)); end
    end
    n_vec++; if (stall_viol !== 0) begin n_err++; $display("FAIL bp_stable got %0d want 0", stall_viol); end
    n_vec++; if (bus.lines_sent !== 16'd2) begin n_err++; $display("FAIL bp_lines got %0d want 2", bus.lines_sent); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = 32'h13121110; w[1] = 32'h23222120; w[2] = 32'h33323130;
    clear_cap();
    for (int i = 0; i < 3; i++) q.push_back(w[i]);
    drive_fifo();
    repeat (18) cycle(1'b1);
    n_vec++; if (cap_d.size() !== 3*BPL) begin n_err++; $display("FAIL b2b_count got %0d want %0d", cap_d.size(), 3*BPL); end
    if (cap_c.size() == 3*BPL) begin
      n_vec++; if (cap_c[3*BPL-1] - cap_c[0] !== 3*BPL-1) begin n_err++; $display("FAIL b2b_gap span %0d want %0d", cap_c[3*BPL-1] - cap_c[0], 3*BPL-1); end
    end
    for (int k = 0; k < 3*BPL && k < cap_d.size(); k++) begin
      n_vec++; if (cap_d[k] !== exp_byte(w[k/BPL], k%BPL)) begin n_err++; $display("FAIL b2b_byte%0d got %h want %h", k, cap_d[k], exp_byte(w[k/BPL], k%BPL)); end
      n_vec++; if (cap_l[k] !== (k%BPL == BPL-1)) begin n_err++; $display("FAIL b2b_last%0d got %b want %b", k, cap_l[k], (k%BPL == BPL-1)); end
    end
    n_vec++; if (pop_at.size() !== 3) begin n_err++; $display("FAIL b2b_pops got %0d want 3", pop_at.size()); end
    for (int i = 0; i < 3 && i < pop_at.size(); i++) begin
      n_vec++; if (pop_at[i] !== i*BPL) begin n_err++; $display("FAIL b2b_pop%0d at beat %0d want %0d", i, pop_at[i], i*BPL); end
    end
    n_vec++; if (bus.lines_sent !== 16'd5) begin n_err++; $display("FAIL b2b_lines got %0d want 5", bus.lines_sent); end
  endtask

  task automatic test_reset_mid();
    int guard;
    clear_cap();
    q.push_back(32'h53525150);
    q.push_back(32'h63626160);
    drive_fifo();
    guard = 0;
    while (cap_d.size() < 2 && guard < 10) begin cycle(1'b1); guard++; end
    n_vec++; if (cap_d.size() !== 2) begin n_err++; $display("FAIL mid_pre got %0d beats want 2", cap_d.size()); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL mid_rd_en got %b want 0", bus.fifo_rd_en); end
    n_vec++; if (bus.lines_sent !== 16'd0) begin n_err++; $display("FAIL mid_lines got %0d want 0", bus.lines_sent); end
    repeat (2) cycle(1'b1);
    n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL mid_queue got %0d want 1", q.size()); end
    rst_n = 1'b1;
    clear_cap();
    repeat (10) cycle(1'b1);
    n_vec++; if (cap_d.size() !== BPL) begin n_err++; $display("FAIL mid_count got %0d want %0d", cap_d.size(), BPL); end
    for (int k = 0; k < BPL && k < cap_d.size(); k++) begin
      n_vec++; if (cap_d[k] !== exp_byte(32'h63626160, k)) begin n_err++; $display("FAIL mid_byte%0d got %h want %h", k, cap_d[k], exp_byte(32'h63626160, k)); end
    end
    n_vec++; if (bus.lines_sent !== 16'd1) begin n_err++; $display("FAIL mid_lines_after got %0d want 1", bus.lines_sent); end
  endtask

`ifdef LINE_SERIALIZER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] ex [5];
    ex[0] = 8'h01; ex[1] = 8'h02; ex[2] = 8'h03; ex[3] = 8'h04; ex[4] = 8'hF6;
    clear_cap();
    q.push_back(32'h04030201);
    drive_fifo();
    repeat (10) cycle(1'b1);
    n_vec++; if (cap_d.size() !== 5) begin n_err++; $display("FAIL csum_count got %0d want 5", cap_d.size()); end
    for (int k = 0; k < 5 && k < cap_d.size(); k++) begin
      n_vec++; if (cap_d[k] !== ex[k]) begin n_err++; $display("FAIL csum_byte%0d got %h want %h", k, cap_d[k], ex[k]); end
      n_vec++; if (cap_l[k] !== (k == 4)) begin n_err++; $display("FAIL csum_last%0d got %b want %b", k, cap_l[k], (k == 4)); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
`ifdef LINE_SERIALIZER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
